// File: rtl/fft_pkg.sv
// Shared constants and bank-state encoding for the FFT output reorder buffer.
package fft_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = 4;
  localparam int FFT_DW    = 16;

  // Lifecycle of one reorder bank.
  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  // A bank holding a complete frame cannot take writes and may be read.
  function automatic logic bank_busy(input bank_state_t s);
    return (s == BANK_FULL) || (s == BANK_DRAINING);
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Frame storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; bank state decides what is valid.
module fft_reorder_ram #(
  parameter int DEPTH = 32,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];

  // Store one word per accepted sample.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fft_out_reorder.sv
// FFT output reorder buffer: accepts samples in bit-reversed bin order and
// emits them in natural bin order. Samples are written at bitrev(k) and read
// back at ascending addresses.
// Build option: define FFT_REORDER_PINGPONG_EN for two banks that fill and
// drain concurrently; otherwise a single bank alternates between filling and
// draining.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int W = FFT_DW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_push,
  input  logic [W-1:0] in_real,
  input  logic [W-1:0] in_imag,
  output logic         in_stall,
  output logic         out_push_F,
  output logic [W-1:0] out_real_F,
  output logic [W-1:0] out_imag_F,
  input  logic         out_stall
);

  localparam int LOG2N = $clog2(N);
`ifdef FFT_REORDER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int AW = $clog2(NB * N);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  bank_state_t      r_state [NB];
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [LOG2N-1:0] r_wr_cnt;
  logic [LOG2N-1:0] r_rd_cnt;
  logic [LOG2N-1:0] w_wr_addr;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic [2*W-1:0]   w_rd_data;
  logic             w_accept;
  logic             w_pop;
  logic             w_wr_last;
  logic             w_rd_last;
  logic             w_wr_bank_next;
  logic             w_rd_bank_next;

  // Handshake decisions depend only on registered bank state.
  assign in_stall  = bank_busy(r_state[r_wr_bank]);
  assign w_accept  = in_push & ~in_stall;
  assign w_pop     = ~out_stall & bank_busy(r_state[r_rd_bank]);
  assign w_wr_last = (r_wr_cnt == LAST_IDX);
  assign w_rd_last = (r_rd_cnt == LAST_IDX);

  // With a single bank both pointers stay on bank 0.
  assign w_wr_bank_next = (NB == 2) ? ~r_wr_bank : 1'b0;
  assign w_rd_bank_next = (NB == 2) ? ~r_rd_bank : 1'b0;

  // Write address is the sample counter with its bits mirrored.
  for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
    assign w_wr_addr[gi] = r_wr_cnt[LOG2N-1-gi];
  end

  if (NB == 2) begin : g_idx_pp
    assign w_wr_idx = {r_wr_bank, w_wr_addr};
    assign w_rd_idx = {r_rd_bank, r_rd_cnt};
  end else begin : g_idx_single
    assign w_wr_idx = w_wr_addr;
    assign w_rd_idx = r_rd_cnt;
  end

  fft_reorder_ram #(
    .DEPTH (NB * N),
    .DW    (2 * W),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_addr (w_wr_idx),
    .i_wr_data ({in_real, in_imag}),
    .i_rd_addr (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  // Write pointer: count accepted samples, move to the next bank after the last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_accept) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_wr_last) begin
        r_wr_bank <= w_wr_bank_next;
      end
    end
  end

  // Read pointer and registered output word; data holds while no pop occurs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_cnt   <= '0;
      r_rd_bank  <= 1'b0;
      out_push_F <= 1'b0;
      out_real_F <= '0;
      out_imag_F <= '0;
    end else begin
      out_push_F <= w_pop;
      if (w_pop) begin
        out_real_F <= w_rd_data[2*W-1:W];
        out_imag_F <= w_rd_data[W-1:0];
        r_rd_cnt   <= r_rd_cnt + 1'b1;
        if (w_rd_last) begin
          r_rd_bank <= w_rd_bank_next;
        end
      end
    end
  end

  // Per-bank lifecycle; a bank is never written and popped in the same edge.
  for (genvar gi = 0; gi < NB; gi++) begin : g_bank
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state[gi] <= BANK_EMPTY;
      end else if (w_accept && (r_wr_bank == 1'(gi))) begin
        r_state[gi] <= w_wr_last ? BANK_FULL : BANK_FILLING;
      end else if (w_pop && (r_rd_bank == 1'(gi))) begin
        r_state[gi] <= w_rd_last ? BANK_EMPTY : BANK_DRAINING;
      end
    end
  end

endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 SHALL have parameters: N, default 16, points per frame; W, default 16, component width.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: in_push  input  1  producer offers one sample this cycle.
REQ-005 SHALL have ports: in_real, in_imag  input  W each  sample in bit-reversed bin order, two's complement.
REQ-006 SHALL have ports: in_stall  output  1  block cannot accept a sample this cycle.
REQ-007 SHALL have ports: out_push_F  output  1  registered valid; one sample per high cycle.
REQ-008 SHALL have ports: out_real_F, out_imag_F  output  W each  registered sample in natural bin order.
REQ-009 SHALL have ports: out_stall  input  1  consumer requests no further pushes.

Function
REQ-010 SHALL accept a sample at a rising edge iff in_push=1 and in_stall=0; in_push while in_stall=1 SHALL be ignored, with no write and no count change.
REQ-011 SHALL write the k-th accepted sample of a frame (k=0..N-1) to bank address bitrev(k), log2(N) bits reversed.
REQ-012 SHALL read a FULL bank at addresses 0..N-1 in ascending order.
REQ-013 SHALL track each bank in states EMPTY->FILLING (first write)->FULL (N-th write)->DRAINING (first pop)->EMPTY (N-th pop).
REQ-014 SHALL drive in_stall combinationally from registered state: high iff the current write bank is FULL or DRAINING.
REQ-015 SHALL register a pop at an edge iff out_stall=0 and the read bank is FULL or DRAINING; out_push_F=1 with that word from that edge, else out_push_F=0.
REQ-016 SHALL hold out_real_F/out_imag_F unchanged when out_push_F=0.
REQ-017 SHALL have a latency of exactly one edge: if the N-th sample is accepted at edge E, index 0 is output at edge E+1 when out_stall=0.
REQ-018 SHALL react to out_stall within one edge; a push already registered counts as transferred.
REQ-019 SHALL toggle the write bank after the N-th write and the read bank after the N-th pop; the pointers wrap modulo the bank count.
REQ-020 SHALL honour simultaneous events: the N-th write to one bank and the N-th pop from the other in the same edge are both performed.
REQ-021 SHALL output frames back-to-back without a bubble when the next frame is FULL at the last pop.
REQ-022 SHALL transfer data without modification (no scaling or rounding).

Reset
REQ-023 SHALL, on reset (asynchronous assert, synchronous-safe deassert), set all banks EMPTY, both pointers to bank 0, counters 0, out_push_F=0, out_real_F=out_imag_F=0.
REQ-024 SHALL discard partial frames on reset mid-operation; RAM contents need not be cleared.

Configuration
REQ-025 SHALL, with FFT_REORDER_PINGPONG_EN defined, provide two banks that fill and drain concurrently.
REQ-026 SHALL, without FFT_REORDER_PINGPONG_EN, provide one bank; in_stall stays high from the N-th write edge until the edge emitting index N-1.

Structure
REQ-027 SHALL take FFT_N=16, FFT_LOG2N=4, FFT_DW=16 and the bank-state encoding from shared package fft_pkg.
REQ-028 SHALL place storage in sub-module fft_reorder_ram: banks x N x 2W, one synchronous write port, one asynchronous read port.

Verification
REQ-029 SHALL pass single frame: in_real=k, in_imag=0x100+k for k=0..15, out_stall=0 -> out_real_F sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, matching imag +0x100, index 0 at E+1.
REQ-030 SHALL pass two frames streamed continuously with PINGPONG_EN -> 32 consecutive out_push_F cycles, in_stall never high.
REQ-031 SHALL pass out_stall held high for 5 cycles after output index 3 -> out_push_F low one edge later, resumes with index 4, no loss or duplicate.
REQ-032 SHALL pass stimulus without PINGPONG_EN: second frame offered immediately -> in_stall high for 16 cycles, second frame correct.
REQ-033 SHALL pass reset asserted after 7 inputs -> out_push_F=0 immediately, next full frame outputs correctly.
REQ-034 SHALL pass in_push with in_stall=1 and garbage data 0xDEAD -> never appears at output.
